// File: rtl/key_pio_pkg.sv
// Shared definitions for the debounced key PIO: register map addresses and bus width.
package key_pio_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RAW   = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_RISE  = 3'd4;
  localparam logic [2:0] ADDR_FALL  = 3'd5;
  localparam logic [2:0] ADDR_DBPER = 3'd6;

endpackage

// File: rtl/key_debounce_pio_if.sv
// Avalon-MM s1 slave signal bundle for the debounced key PIO.
interface key_debounce_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/key_debounce_pio_ch.sv
// One key channel: two-flop synchroniser, debounce counter, stable level and
// single-cycle rise/fall indications aligned with the edge that updates stable.
module key_debounce_ch #(
  parameter int unsigned DB_W       = 16,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_raw,
  input  logic [DB_W-1:0] db_period,
  output logic            raw_sync,
  output logic            stable,
  output logic            rise,
  output logic            fall
);

  logic            s1_q;
  logic            s1_d;
  logic            s2_q;
  logic            s2_d;
  logic            stable_q;
  logic            stable_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;
  logic [DB_W:0]   cnt_inc_s;
  logic [DB_W:0]   limit_s;

  // A period of zero behaves like one; the extra bit keeps cnt+1 from wrapping.
  always_comb begin
    s1_d      = in_raw;
    s2_d      = s1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    cnt_inc_s = {1'b0, cnt_q} + {{DB_W{1'b0}}, 1'b1};
    if (db_period == {DB_W{1'b0}}) begin
      limit_s = {{DB_W{1'b0}}, 1'b1};
    end else begin
      limit_s = {1'b0, db_period};
    end
    if (s2_q == stable_q) begin
      cnt_d = {DB_W{1'b0}};
    end else if (cnt_inc_s >= limit_s) begin
      stable_d = s2_q;
      cnt_d    = {DB_W{1'b0}};
    end else begin
      cnt_d = cnt_inc_s[DB_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= IDLE_LEVEL;
      s2_q     <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= {DB_W{1'b0}};
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign raw_sync = s2_q;
  assign stable   = stable_q;
  assign rise     = stable_d & ~stable_q;
  assign fall     = ~stable_d & stable_q;

endmodule

// File: rtl/key_debounce_pio.sv
// Debounced key input port on the s1 bus: control registers, write-1-to-clear
// edge capture, registered read mux and masked level interrupt.
module key_debounce_pio
  import key_pio_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DB_W       = 16,
  parameter int unsigned DB_RESET   = 50000,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  key_debounce_pio_if.slave  s1,
  input  logic [WIDTH-1:0]   in_port,
  output logic               irq
);

  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_s;
  logic             wdata_unused_s;

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] rise_en_d;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] fall_en_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [DB_W-1:0]  dbper_q;
  logic [DB_W-1:0]  dbper_d;
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] rdata_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_ch #(
      .DB_W       (DB_W),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_raw    (in_port[i]),
      .db_period (dbper_q),
      .raw_sync  (raw_s[i]),
      .stable    (stable_s[i]),
      .rise      (rise_s[i]),
      .fall      (fall_s[i])
    );
  end

  assign wr_s           = s1.chipselect & ~s1.write_n;
  assign wdata_unused_s = ^s1.writedata;

  always_comb begin
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    dbper_d   = dbper_q;
    clr_s     = {WIDTH{1'b0}};
    if (wr_s) begin
      case (s1.address)
        ADDR_MASK:  mask_d    = s1.writedata[WIDTH-1:0];
        ADDR_EDGE:  clr_s     = s1.writedata[WIDTH-1:0];
        ADDR_RISE:  rise_en_d = s1.writedata[WIDTH-1:0];
        ADDR_FALL:  fall_en_d = s1.writedata[WIDTH-1:0];
        ADDR_DBPER: dbper_d   = s1.writedata[DB_W-1:0];
        default:    clr_s     = {WIDTH{1'b0}};
      endcase
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    // Set terms are OR-ed after the clear so a same-cycle edge wins over W1C.
    edge_d = (edge_q & ~clr_s) | (rise_s & rise_en_q) | (fall_s & fall_en_q);
  end

  always_comb begin
    rdata_d = {BUS_W{1'b0}};
    case (s1.address)
      ADDR_DATA:  rdata_d[WIDTH-1:0] = stable_s;
      ADDR_RAW:   rdata_d[WIDTH-1:0] = raw_s;
      ADDR_MASK:  rdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE:  rdata_d[WIDTH-1:0] = edge_q;
      ADDR_RISE:  rdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_FALL:  rdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_DBPER: rdata_d[DB_W-1:0]  = dbper_q;
      default:    rdata_d            = {BUS_W{1'b0}};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= {WIDTH{1'b0}};
      rise_en_q <= {WIDTH{1'b0}};
      fall_en_q <= {WIDTH{1'b1}};
      edge_q    <= {WIDTH{1'b0}};
      dbper_q   <= DB_W'(DB_RESET);
      rdata_q   <= {BUS_W{1'b0}};
    end else begin
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      edge_q    <= edge_d;
      dbper_q   <= dbper_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s1.readdata = rdata_q;
  assign irq         = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_debounce_pio.sv
// Self-checking bench for key_debounce_pio: bus reads are scoreboarded through a
// queue of expected values; irq and debounce timing are checked edge by edge.
module tb_key_debounce_pio;
  import key_pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  logic       irq;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  key_debounce_pio_if bus ();

  key_debounce_pio #(
    .WIDTH      (4),
    .DB_W       (16),
    .DB_RESET   (50000),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s1      (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    chk(tag_q.pop_front(), bus.readdata, exp_q.pop_front());
  endtask

  // Checks irq after each of the next n edges; expected high from edge 'at' on.
  task automatic watch_irq(input int n, input int at, input string tag);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      chk(tag, {31'd0, irq}, (k >= at) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_port = 4'hF;
    bus_idle();
    repeat (3) @(negedge clk);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    // T1: reset values
    rd(ADDR_DATA,  32'hF,     "t1_data");
    rd(ADDR_RAW,   32'hF,     "t1_raw");
    rd(ADDR_MASK,  32'h0,     "t1_mask");
    rd(ADDR_EDGE,  32'h0,     "t1_edge");
    rd(ADDR_RISE,  32'h0,     "t1_rise");
    rd(ADDR_FALL,  32'hF,     "t1_fall");
    rd(ADDR_DBPER, 32'd50000, "t1_dbper");
    rd(3'd7,       32'h0,     "t1_addr7");

    // T2: falling press on ch0 with period 4; upper DBPER bits dropped
    wr(ADDR_DBPER, 32'h0001_0004);
    rd(ADDR_DBPER, 32'd4, "t2_dbper_trunc");
    wr(ADDR_FALL, 32'h1);
    wr(ADDR_MASK, 32'h1);
    @(negedge clk);
    in_port[0]     = 1'b0;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) chk("t2_irq_e5", {31'd0, irq}, 32'd0);
      if (k == 6) chk("t2_irq_e6", {31'd0, irq}, 32'd1);
      if (k == 6) chk("t2_data_e6", bus.readdata, 32'hF);
      if (k == 7) chk("t2_data_e7", bus.readdata, 32'hE);
    end
    rd(ADDR_EDGE, 32'h1, "t2_edge");
    wr(ADDR_EDGE, 32'h1);
    rd(ADDR_EDGE, 32'h0, "t2_edge_clr");

    // T3: 3-cycle glitch on ch1 never reaches stable
    wr(ADDR_FALL, 32'hF);
    wr(ADDR_MASK, 32'hF);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      in_port[1] = (k < 3) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      chk("t3_irq", {31'd0, irq}, 32'd0);
    end
    rd(ADDR_DATA, 32'hE, "t3_data");
    rd(ADDR_EDGE, 32'h0, "t3_edge");

    // T4: rise-only capture on ch2
    wr(ADDR_RISE, 32'h4);
    wr(ADDR_FALL, 32'h0);
    @(negedge clk);
    in_port[2] = 1'b0;
    watch_irq(10, 100, "t4_press_irq");
    rd(ADDR_EDGE, 32'h0, "t4_edge_press");
    rd(ADDR_DATA, 32'hA, "t4_data_press");
    @(negedge clk);
    in_port[2] = 1'b1;
    watch_irq(10, 6, "t4_rel_irq");
    rd(ADDR_EDGE, 32'h4, "t4_edge_rel");
    wr(ADDR_EDGE, 32'h4);
    rd(ADDR_EDGE, 32'h0, "t4_edge_clr");
    chk("t4_irq_clr", {31'd0, irq}, 32'd0);

    // T5: W1C on the very edge ch0 captures a rise
    wr(ADDR_RISE, 32'h5);
    @(negedge clk);
    in_port[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus.address    = ADDR_EDGE;
    bus.writedata  = 32'h1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus_idle();
    rd(ADDR_EDGE, 32'h1, "t5_edge_setwins");
    rd(ADDR_DATA, 32'hF, "t5_data");
    chk("t5_irq", {31'd0, irq}, 32'd1);
    wr(ADDR_EDGE, 32'hF);
    rd(ADDR_EDGE, 32'h0, "t5_edge_clr");

    // T6: period 0 and 1 both give 3-edge latency on ch3
    wr(ADDR_RISE, 32'h8);
    wr(ADDR_FALL, 32'h8);
    wr(ADDR_MASK, 32'h8);
    wr(ADDR_DBPER, 32'h0);
    @(negedge clk);
    in_port[3] = 1'b0;
    watch_irq(6, 3, "t6_p0_irq");
    wr(ADDR_EDGE, 32'h8);
    wr(ADDR_DBPER, 32'h1);
    @(negedge clk);
    in_port[3] = 1'b1;
    watch_irq(6, 3, "t6_p1_irq");
    rd(ADDR_DATA, 32'hF, "t6_data");
    wr(ADDR_EDGE, 32'h8);

    // T6: reset mid-count leaves no capture behind
    wr(ADDR_DBPER, 32'h4);
    @(negedge clk);
    in_port[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    in_port = 4'hF;
    repeat (2) @(negedge clk);
    chk("t6_irq_in_rst", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    rd(ADDR_EDGE,  32'h0,     "t6_edge_after_rst");
    rd(ADDR_DATA,  32'hF,     "t6_data_after_rst");
    rd(ADDR_FALL,  32'hF,     "t6_fall_after_rst");
    rd(ADDR_DBPER, 32'd50000, "t6_dbper_after_rst");
    chk("t6_irq_after_rst", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
